// File: rtl/jam_pkg.sv
// Shared constants and state encoding for the JAM cost server and its table.
package jam_pkg;

    localparam int JAM_N     = 8;
    localparam int COST_W    = 7;
    localparam int MINCOST_W = 10;
    localparam int CNT_W_DEF = 20;
    localparam int ADDR_W    = 6;
    localparam int MATCH_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SERVE,
        S_REPORT,
        S_DONE
    } jam_state_e;

endpackage

// File: rtl/jam_cost_table.sv
// 64-entry cost register file: one synchronous write port and one
// combinational read port indexed by {W,J}.
module jam_cost_table #(
    parameter int COST_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [5:0]        wAddr_i,
    input  logic [COST_W-1:0] wData_i,
    input  logic [5:0]        rAddr_i,
    output logic [COST_W-1:0] rData_o
);

    logic [COST_W-1:0] mem_q [64];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[wAddr_i] <= wData_i;
        end
    end

    assign rData_o = mem_q[rAddr_i];

endmodule

// File: rtl/jam_cost_server.sv
// Host-side companion for JAM: loads the cost table, holds JAM in reset until
// the table is complete, times the run and hands the result back to the host.
module jam_cost_server #(
    parameter int COST_W = jam_pkg::COST_W,
    parameter int CNT_W  = jam_pkg::CNT_W_DEF
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           LD_VALID,
    output logic                           LD_READY,
    input  logic [COST_W-1:0]              LD_DATA,
    input  logic                           CLEAR,
    output logic                           JAM_RST,
    input  logic [2:0]                     W,
    input  logic [2:0]                     J,
    output logic [COST_W-1:0]              Cost,
    input  logic                           Valid,
    input  logic [jam_pkg::MINCOST_W-1:0]  MinCost,
    input  logic [jam_pkg::MATCH_W-1:0]    MatchCount,
    output logic                           RES_VALID,
    input  logic                           RES_READY,
    output logic [jam_pkg::MINCOST_W-1:0]  RES_COST,
    output logic [jam_pkg::MATCH_W-1:0]    RES_COUNT,
    output logic [CNT_W-1:0]               RUN_CYCLES
);

    import jam_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    jam_state_e              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        runCnt_q, runCnt_d;
    logic [MINCOST_W-1:0]    resCost_q, resCost_d;
    logic [MATCH_W-1:0]      resCount_q, resCount_d;
    logic                    jamRst_q, jamRst_d;
    logic                    tblWe;

    jam_cost_table #(
        .COST_W (COST_W)
    ) u_table (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .we_i    (tblWe),
        .wAddr_i (addr_q),
        .wData_i (LD_DATA),
        .rAddr_i ({W, J}),
        .rData_o (Cost)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            runCnt_q   <= '0;
            resCost_q  <= '0;
            resCount_q <= '0;
            jamRst_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            runCnt_q   <= runCnt_d;
            resCost_q  <= resCost_d;
            resCount_q <= resCount_d;
            jamRst_q   <= jamRst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        runCnt_d   = runCnt_q;
        resCost_d  = resCost_q;
        resCount_d = resCount_q;
        tblWe      = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_LOAD;
            S_LOAD: begin
                if (LD_VALID) begin
                    tblWe  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (addr_q == 6'd63) begin
                        state_d = S_SERVE;
                    end
                end
            end
            S_SERVE: begin
                if (runCnt_q != CNT_MAX) begin
                    runCnt_d = runCnt_q + 1'b1;
                end
                if (Valid) begin
                    resCost_d  = MinCost;
                    resCount_d = MatchCount;
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                if (RES_READY) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // CLEAR overrides everything above, including a same-cycle load beat or capture.
        if (CLEAR && (state_q != S_IDLE)) begin
            state_d    = S_LOAD;
            addr_d     = '0;
            runCnt_d   = '0;
            resCost_d  = resCost_q;
            resCount_d = resCount_q;
            tblWe      = 1'b0;
        end

        jamRst_d = (state_d != S_SERVE);
    end

    assign LD_READY   = (state_q == S_LOAD);
    assign RES_VALID  = (state_q == S_REPORT);
    assign JAM_RST    = jamRst_q;
    assign RES_COST   = resCost_q;
    assign RES_COUNT  = resCount_q;
    assign RUN_CYCLES = runCnt_q;

endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: table vectors, randomized loads and
// runs against a behavioural model, and hand-written handshake/CLEAR/reset cases.
module tb_jam_cost_server;

    localparam int COST_W = 7;
    localparam int CNT_W  = 20;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              LD_VALID;
    logic [COST_W-1:0] LD_DATA;
    logic              CLEAR;
    logic [2:0]        W, J;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              RES_READY;

    logic              LD_READY, JAM_RST, RES_VALID;
    logic [COST_W-1:0] Cost;
    logic [9:0]        RES_COST;
    logic [3:0]        RES_COUNT;
    logic [CNT_W-1:0]  RUN_CYCLES;

    logic              smLdReady, smJamRst, smResValid;
    logic [COST_W-1:0] smCost;
    logic [9:0]        smResCost;
    logic [3:0]        smResCount;
    logic [3:0]        smRunCycles;

    jam_cost_server #(.COST_W(COST_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
        .LD_DATA(LD_DATA), .CLEAR(CLEAR), .JAM_RST(JAM_RST), .W(W), .J(J),
        .Cost(Cost), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_COST(RES_COST),
        .RES_COUNT(RES_COUNT), .RUN_CYCLES(RUN_CYCLES)
    );

    // Narrow-counter copy sharing all stimulus, used to observe saturation.
    jam_cost_server #(.COST_W(COST_W), .CNT_W(4)) dutSmall (
        .CLK(CLK), .RST_N(RST_N), .LD_VALID(LD_VALID), .LD_READY(smLdReady),
        .LD_DATA(LD_DATA), .CLEAR(CLEAR), .JAM_RST(smJamRst), .W(W), .J(J),
        .Cost(smCost), .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
        .RES_VALID(smResValid), .RES_READY(RES_READY), .RES_COST(smResCost),
        .RES_COUNT(smResCount), .RUN_CYCLES(smRunCycles)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] w;
        logic [2:0] j;
        logic [6:0] expCost;
    } vec_t;

    int         vecCount  = 0;
    int         failCount = 0;
    int         serveTicks;
    logic [6:0] modelTbl [64];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic checkCost(input logic [2:0] w, input logic [2:0] j, input string name);
        W = w;
        J = j;
        #1;
        checkOutput(name, 32'(Cost), 32'(modelTbl[{w, j}]));
    endtask

    task automatic serveTick;
        tick;
        serveTicks++;
    endtask

    task automatic doClear;
        CLEAR = 1'b1;
        tick;
        CLEAR = 1'b0;
    endtask

    // Streams modelTbl into the server; gapMode 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
    task automatic applyStimulus(input int gapMode, input int expCycles);
        int   beats = 0;
        int   cyc = 0;
        int   readyCyc = 0;
        int   rstCyc = 0;
        logic v;
        while (beats < 64 && cyc < 1000) begin
            case (gapMode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            LD_VALID = v;
            LD_DATA  = v ? modelTbl[beats] : 7'($urandom);
            if (LD_READY) readyCyc++;
            if (JAM_RST) rstCyc++;
            if (v) beats++;
            tick;
            cyc++;
        end
        LD_VALID = 1'b0;
        if (expCycles > 0) checkOutput("loadCycles", 32'(cyc), 32'(expCycles));
        checkOutput("loadReadyCycles", 32'(readyCyc), 32'(cyc));
        checkOutput("loadJamRstHeld", 32'(rstCyc), 32'(cyc));
        checkOutput("loadDoneReady", 32'(LD_READY), 32'd0);
        checkOutput("loadDoneJamRst", 32'(JAM_RST), 32'd0);
        checkOutput("loadDoneRunCycles", 32'(RUN_CYCLES), 32'd0);
    endtask

    // Exhaustive assignment search over all 8! permutations of the model table.
    task automatic bruteForce(output int minCost, output int matchCount);
        int p[8];
        int sum, i, k, t;
        for (int n = 0; n < 8; n++) p[n] = n;
        minCost = 1 << 30;
        matchCount = 0;
        forever begin
            sum = 0;
            for (int w = 0; w < 8; w++) sum += int'(modelTbl[w * 8 + p[w]]);
            if (sum < minCost) begin
                minCost = sum;
                matchCount = 1;
            end else if (sum == minCost) begin
                matchCount++;
            end
            i = 6;
            while (i >= 0 && p[i] >= p[i + 1]) i--;
            if (i < 0) break;
            k = 7;
            while (p[k] <= p[i]) k--;
            t = p[i]; p[i] = p[k]; p[k] = t;
            for (int a = i + 1, b = 7; a < b; a++, b--) begin
                t = p[a]; p[a] = p[b]; p[b] = t;
            end
        end
    endtask

    task automatic checkResult(input int expCost, input int expCount, input int expCycles, input string tag);
        checkOutput({tag, "_resValid"}, 32'(RES_VALID), 32'd1);
        checkOutput({tag, "_resCost"}, 32'(RES_COST), 32'(expCost));
        checkOutput({tag, "_resCount"}, 32'(RES_COUNT), 32'(expCount));
        checkOutput({tag, "_runCycles"}, 32'(RUN_CYCLES), 32'(expCycles));
        checkOutput({tag, "_jamRst"}, 32'(JAM_RST), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   minC, cntC, n, expCost, expCount;

        vecs[0] = '{3'd3, 3'd5, 7'd29};
        vecs[1] = '{3'd0, 3'd0, 7'd0};
        vecs[2] = '{3'd7, 3'd7, 7'd63};
        vecs[3] = '{3'd1, 3'd2, 7'd10};
        vecs[4] = '{3'd7, 3'd0, 7'd56};
        vecs[5] = '{3'd2, 3'd7, 7'd23};

        RST_N = 1'b0; LD_VALID = 1'b0; LD_DATA = '0; CLEAR = 1'b0;
        W = 3'd3; J = 3'd5; Valid = 1'b0; MinCost = '0; MatchCount = '0; RES_READY = 1'b0;
        #12;
        checkOutput("rstJamRst", 32'(JAM_RST), 32'd1);
        checkOutput("rstLdReady", 32'(LD_READY), 32'd0);
        checkOutput("rstResValid", 32'(RES_VALID), 32'd0);
        checkOutput("rstResCost", 32'(RES_COST), 32'd0);
        checkOutput("rstResCount", 32'(RES_COUNT), 32'd0);
        checkOutput("rstRunCycles", 32'(RUN_CYCLES), 32'd0);
        checkOutput("rstCost", 32'(Cost), 32'd0);
        RST_N = 1'b1;
        tick;
        checkOutput("idleToLoadReady", 32'(LD_READY), 32'd1);
        checkOutput("idleToLoadJamRst", 32'(JAM_RST), 32'd1);

        // Back-to-back load of table[a] = a mod 128.
        for (int a = 0; a < 64; a++) modelTbl[a] = 7'(a % 128);
        applyStimulus(0, 64);
        serveTicks = 0;
        for (int i = 0; i < 6; i++) begin
            W = vecs[i].w;
            J = vecs[i].j;
            #1;
            checkOutput($sformatf("tblVec%0d", i), 32'(Cost), 32'(vecs[i].expCost));
            serveTick;
        end
        for (int i = 0; i < 20; i++) begin
            checkCost(3'($urandom), 3'($urandom), "randRead");
            serveTick;
        end
        while (serveTicks < 30) serveTick;
        checkOutput("runCycles30", 32'(RUN_CYCLES), 32'd30);
        checkOutput("smallSaturated", 32'(smRunCycles), 32'd15);
        while (serveTicks < 100) serveTick;
        checkOutput("runCycles100", 32'(RUN_CYCLES), 32'd100);
        checkOutput("serveJamRst", 32'(JAM_RST), 32'd0);

        // CLEAR together with Valid and a stray load beat: no capture.
        CLEAR = 1'b1; Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd5;
        LD_VALID = 1'b1; LD_DATA = 7'd99;
        tick;
        CLEAR = 1'b0; Valid = 1'b0; LD_VALID = 1'b0;
        checkOutput("clrJamRst", 32'(JAM_RST), 32'd1);
        checkOutput("clrLdReady", 32'(LD_READY), 32'd1);
        checkOutput("clrRunCycles", 32'(RUN_CYCLES), 32'd0);
        checkOutput("clrSmallRunCycles", 32'(smRunCycles), 32'd0);
        checkOutput("clrResValid", 32'(RES_VALID), 32'd0);
        checkOutput("clrResCost", 32'(RES_COST), 32'd0);
        checkOutput("clrResCount", 32'(RES_COUNT), 32'd0);

        // Gapped load with random data; idle cycles carry garbage that must not land.
        for (int a = 0; a < 64; a++) modelTbl[a] = 7'($urandom);
        applyStimulus(1, 127);
        for (int a = 0; a < 64; a++) checkCost(3'(a / 8), 3'(a % 8), "gapRead");

        // Diagonal table, JAM emulated by the bench.
        doClear;
        for (int a = 0; a < 64; a++) modelTbl[a] = (a / 8 == a % 8) ? 7'd0 : 7'd10;
        applyStimulus(0, 64);
        bruteForce(minC, cntC);
        checkOutput("diagModelMin", 32'(minC), 32'd0);
        serveTicks = 0;
        for (int c = 0; c < 40; c++) begin
            checkCost(3'(c / 8), 3'(c % 8), "jamLookup");
            serveTick;
        end
        Valid = 1'b1; MinCost = 10'(minC); MatchCount = 4'(cntC);
        serveTick;
        Valid = 1'b0;
        checkResult(minC, cntC, serveTicks, "diag");
        checkOutput("diagRunNonzero", 32'(RUN_CYCLES != 0), 32'd1);
        for (int c = 0; c < 5; c++) begin
            Valid = 1'b1; MinCost = 10'($urandom); MatchCount = 4'($urandom);
            tick;
            checkResult(minC, cntC, serveTicks, "hold");
        end
        Valid = 1'b0;
        RES_READY = 1'b1;
        tick;
        RES_READY = 1'b0;
        checkOutput("doneResValid", 32'(RES_VALID), 32'd0);
        checkOutput("doneResCost", 32'(RES_COST), 32'(minC));
        checkOutput("doneJamRst", 32'(JAM_RST), 32'd1);
        tick;
        checkOutput("doneLdReady", 32'(LD_READY), 32'd0);

        // Randomized runs against the model.
        for (int r = 0; r < 3; r++) begin
            doClear;
            checkOutput("rndClrRun", 32'(RUN_CYCLES), 32'd0);
            for (int a = 0; a < 64; a++) modelTbl[a] = 7'($urandom);
            applyStimulus(2, 0);
            serveTicks = 0;
            n = $urandom_range(5, 40);
            for (int k = 0; k < n; k++) begin
                checkCost(3'($urandom), 3'($urandom), "rndLookup");
                serveTick;
            end
            expCost  = $urandom_range(1, 1023);
            expCount = $urandom_range(1, 15);
            Valid = 1'b1; MinCost = 10'(expCost); MatchCount = 4'(expCount);
            serveTick;
            Valid = 1'b0; MinCost = 10'($urandom);
            checkResult(expCost, expCount, serveTicks, "rnd");
            checkOutput("rndSmallRun", 32'(smRunCycles), 32'((serveTicks > 15) ? 15 : serveTicks));
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) tick;
            RES_READY = 1'b1;
            tick;
            RES_READY = 1'b0;
            checkOutput("rndDoneValid", 32'(RES_VALID), 32'd0);
            checkOutput("rndDoneCount", 32'(RES_COUNT), 32'(expCount));
        end

        // Asynchronous reset in the middle of a load.
        doClear;
        for (int a = 0; a < 10; a++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 7'(8'h40 | a);
            tick;
        end
        #2;
        RST_N = 1'b0;
        W = 3'd0; J = 3'd1;
        #1;
        checkOutput("arstLdReady", 32'(LD_READY), 32'd0);
        checkOutput("arstJamRst", 32'(JAM_RST), 32'd1);
        checkOutput("arstResValid", 32'(RES_VALID), 32'd0);
        checkOutput("arstResCost", 32'(RES_COST), 32'd0);
        checkOutput("arstResCount", 32'(RES_COUNT), 32'd0);
        checkOutput("arstRunCycles", 32'(RUN_CYCLES), 32'd0);
        checkOutput("arstCost", 32'(Cost), 32'd0);
        LD_VALID = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end

endmodule
